// File: rtl/watch_ctrl_pkg.sv
// Shared encodings for the watch time-set controller: FSM states double as o_field codes,
// plus the FND blank-mask one-hot constants and field navigation helpers.
package watch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_e;

    localparam logic [2:0] BLANK_NONE = 3'b000;
    localparam logic [2:0] BLANK_HOUR = 3'b100;
    localparam logic [2:0] BLANK_MIN  = 3'b010;
    localparam logic [2:0] BLANK_SEC  = 3'b001;

    function automatic logic [2:0] field_mask(input state_e st);
        case (st)
            ST_SET_HOUR: return BLANK_HOUR;
            ST_SET_MIN:  return BLANK_MIN;
            ST_SET_SEC:  return BLANK_SEC;
            default:     return BLANK_NONE;
        endcase
    endfunction

    function automatic state_e next_field(input state_e st);
        case (st)
            ST_SET_HOUR: return ST_SET_MIN;
            ST_SET_MIN:  return ST_SET_SEC;
            default:     return ST_SET_HOUR;
        endcase
    endfunction

    function automatic state_e prev_field(input state_e st);
        case (st)
            ST_SET_HOUR: return ST_SET_SEC;
            ST_SET_SEC:  return ST_SET_MIN;
            default:     return ST_SET_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/btn_autorepeat.sv
// Edge detector plus hold/repeat timer for the increment button. pulse_o is asserted in the
// cycle the edge is seen, then HOLD_CNT cycles later, then every REPEAT_CNT cycles while held.
module btn_autorepeat #(
    parameter int unsigned HOLD_CNT   = 50_000_000,
    parameter int unsigned REPEAT_CNT = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic kill_i,
    output logic edge_o,
    output logic pulse_o
);
    localparam int unsigned MAX_CNT = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
    localparam int          CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] HOLD_V   = CW'(HOLD_CNT);
    localparam logic [CW-1:0] REPEAT_V = CW'(REPEAT_CNT);
    localparam logic [CW-1:0] MAX_V    = CW'(MAX_CNT);

    logic          prev_q;
    logic          active_q;
    logic          repeat_q;
    logic [CW-1:0] cnt_q;
    logic          at_target;

    assign edge_o    = btn_i & ~prev_q;
    assign at_target = (cnt_q == (repeat_q ? REPEAT_V : HOLD_V));
    assign pulse_o   = ~kill_i & (edge_o | (active_q & btn_i & at_target));

    // NOTE: registered state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= 1'b0;
            active_q <= 1'b0;
            repeat_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            prev_q <= btn_i;
            if (kill_i || !btn_i) begin
                // Once killed, only a fresh press can re-arm, since prev_q tracks the held level.
                active_q <= 1'b0;
                repeat_q <= 1'b0;
                cnt_q    <= '0;
            end else if (edge_o) begin
                active_q <= 1'b1;
                repeat_q <= 1'b0;
                cnt_q    <= CW'(1);
            end else if (active_q) begin
                if (at_target) begin
                    repeat_q <= 1'b1;
                    cnt_q    <= CW'(1);
                end else if (cnt_q < MAX_V) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-set controller: run/hold gate, field selection FSM, increment/clear pulses,
// selected-field blink and set-mode inactivity timeout. All outputs are registered.
module watch_set_ctrl
    import watch_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CNT    = 50_000_000,
    parameter int unsigned REPEAT_CNT  = 10_000_000,
    parameter int unsigned BLINK_CNT   = 25_000_000,
    parameter int unsigned TIMEOUT_CNT = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_L,
    input  logic       btn_R,
    input  logic       btn_U,
    input  logic       btn_D,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_inc_hour,
    output logic       o_inc_min,
    output logic       o_inc_sec,
    output logic [1:0] o_field,
    output logic [2:0] o_blank
);
    localparam int BW = $clog2(BLINK_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_CNT + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);
    localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_CNT);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CNT - 1);
    localparam logic [TW-1:0] IDLE_MAX   = TW'(TIMEOUT_CNT);

    state_e        state_q, state_d;
    logic          mode_prev_q, l_prev_q, r_prev_q, d_prev_q;
    logic          mode_e, l_e, r_e, u_e, d_e;
    logic          kill, inc_fire, restart;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          run_q, clear_q, clear_d, inc_hour_q, inc_min_q, inc_sec_q;
    logic [2:0]    blank_q;

    assign mode_e = btn_mode & ~mode_prev_q;
    assign l_e    = btn_L & ~l_prev_q;
    assign r_e    = btn_R & ~r_prev_q;
    assign d_e    = btn_D & ~d_prev_q;

    // A D edge loses to a same-cycle U edge, so it only kills a repeat already in progress.
    assign kill = (state_q == ST_RUN) | mode_e | l_e | r_e | (d_e & ~u_e);

    btn_autorepeat #(
        .HOLD_CNT   (HOLD_CNT),
        .REPEAT_CNT (REPEAT_CNT)
    ) u_autorepeat (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_U),
        .kill_i  (kill),
        .edge_o  (u_e),
        .pulse_o (inc_fire)
    );

    assign restart = mode_e | l_e | r_e | u_e | d_e | inc_fire;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        if (state_q == ST_RUN) begin
            if (mode_e) state_d = ST_SET_HOUR;
        end else if (mode_e) begin
            state_d = ST_RUN;
        end else if (l_e) begin
            state_d = prev_field(state_q);
        end else if (r_e) begin
            state_d = next_field(state_q);
        end else if (!u_e && d_e) begin
            clear_d = 1'b1;
        end else if (!u_e && !inc_fire && idle_q == IDLE_LAST) begin
            state_d = ST_RUN;
        end

        blink_d = blink_q;
        phase_d = phase_q;
        idle_d  = idle_q;
        if (state_d == ST_RUN || restart) begin
            blink_d = '0;
            phase_d = 1'b0;
            idle_d  = '0;
        end else begin
            if (blink_q == BLINK_LAST) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else if (blink_q < BLINK_MAX) begin
                blink_d = blink_q + 1'b1;
            end
            if (idle_q < IDLE_MAX) idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            mode_prev_q <= 1'b0;
            l_prev_q    <= 1'b0;
            r_prev_q    <= 1'b0;
            d_prev_q    <= 1'b0;
            blink_q     <= '0;
            phase_q     <= 1'b0;
            idle_q      <= '0;
            run_q       <= 1'b1;
            clear_q     <= 1'b0;
            inc_hour_q  <= 1'b0;
            inc_min_q   <= 1'b0;
            inc_sec_q   <= 1'b0;
            blank_q     <= BLANK_NONE;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= btn_mode;
            l_prev_q    <= btn_L;
            r_prev_q    <= btn_R;
            d_prev_q    <= btn_D;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            idle_q      <= idle_d;
            run_q       <= (state_d == ST_RUN);
            clear_q     <= clear_d;
            inc_hour_q  <= inc_fire & (state_q == ST_SET_HOUR);
            inc_min_q   <= inc_fire & (state_q == ST_SET_MIN);
            inc_sec_q   <= inc_fire & (state_q == ST_SET_SEC);
            blank_q     <= field_mask(state_d) & {3{phase_d}};
        end
    end

    assign o_run      = run_q;
    assign o_clear    = clear_q;
    assign o_inc_hour = inc_hour_q;
    assign o_inc_min  = inc_min_q;
    assign o_inc_sec  = inc_sec_q;
    assign o_field    = state_q;
    assign o_blank    = blank_q;

endmodule
